pin_attempt_ctrl: RTL and testbench
===================================

// Module: pin_attempt_ctrl
// PURPOSE
//  Session controller in front of the DebitPin checker. Forwards user keypad digits and submit
//  pulses to the checker, then waits for its verdict. Counts consecutive failed attempts and
//  enforces a timed lockout after MAX_FAILS failures. Drives the checker's reset between
//  attempts, so a single DebitPin instance is reused for every attempt.
// PARAMETERS
//  NUM_DIGITS       4     digits per PIN attempt; CHECK is entered after this many accepted submits
//  MAX_FAILS        3     consecutive failures that trigger COOLDOWN (>=1)
//  COOLDOWN_CYCLES  1000  lockout duration in clk cycles (>=1)
//  RESP_TIMEOUT     8     max cycles in CHECK waiting for correct/incorrect before forced failure
// PORTS
//  clk          in   1                    system clock, rising edge
//  reset        in   1                    asynchronous, active-high
//  user_digits  in   4                    keypad switches; must be one-hot when user_submit=1
//  user_submit  in   1                    single-cycle digit-submit pulse from keypad
//  user_done    in   1                    single-cycle end-of-session pulse while access=1
//  pin_correct  in   1                    checker verdict: PIN matched
//  pin_incorrect in  1                    checker verdict: PIN mismatched
//  pin_bug      in   1                    checker internal-error flag
//  pin_digits   out  4                    registered digits to checker (digit_switches)
//  pin_submit   out  1                    registered submit pulse to checker
//  chk_reset    out  1                    1-cycle reset pulse to checker
//  access       out  1                    high in GRANTED
//  locked       out  1                    high in COOLDOWN
//  fault        out  1                    high in FAULT
//  bad_digit    out  1                    1-cycle pulse: submit rejected (digits not one-hot)
//  fails_left   out  $clog2(MAX_FAILS+1)  MAX_FAILS - consecutive failures
// BEHAVIOUR
//  Reset (async): state=READY; pin_digits=0, pin_submit=0, chk_reset=1 for the first cycle after
//   reset deasserts, then 0; access=locked=fault=bad_digit=0; fails_left=MAX_FAILS; digit_cnt=0.
//  READY: user_submit with one-hot user_digits -> next cycle pin_digits=user_digits,
//   pin_submit=1 for exactly 1 cycle (latency 1), digit_cnt++. When digit_cnt reaches
//   NUM_DIGITS, go to CHECK and load the timer with RESP_TIMEOUT. A non-one-hot submit gives
//   bad_digit=1 next cycle with no forward and no count. Submits are ignored in all other states.
//  CHECK: pin_correct -> GRANTED, fails_left=MAX_FAILS.
//   pin_incorrect, or timer expiry -> one failure; fails_left--.
//    If fails_left becomes 0 -> COOLDOWN, timer=COOLDOWN_CYCLES.
//    Else -> READY with chk_reset pulse.
//   pin_correct and pin_incorrect asserted together -> treated as pin_bug.
//  GRANTED: access=1 until user_done -> chk_reset pulse, digit_cnt=0, READY.
//  COOLDOWN: locked=1; timer decrements each cycle. When timer reaches 0 -> chk_reset pulse,
//   fails_left=MAX_FAILS, digit_cnt=0, READY. Exact lock length is COOLDOWN_CYCLES cycles.
//  Every chk_reset pulse clears digit_cnt. fails_left saturates at 0 and never wraps.
//  pin_bug has priority over every other input in every state except FAULT; handling is set by
//   BUG_RECOVER_EN (see CONFIGURATION).
//  Reset mid-operation returns to the reset values immediately, regardless of state.
// CONFIGURATION
//  PIN_BUG_RECOVER_EN undefined: pin_bug -> FAULT. FAULT is sticky: fault=1, access=0, and only
//   reset leaves it.
//  PIN_BUG_RECOVER_EN defined: pin_bug -> chk_reset pulse and counts as one failure
//   (COOLDOWN if fails_left hits 0, else READY). FAULT is unreachable.
// STRUCTURE
//  pin_ctrl_pkg: state enum {READY, CHECK, GRANTED, COOLDOWN, FAULT}, is_onehot4() function,
//   FAIL_W localparam helper.
//  Sub-module pin_ctrl_timer: loadable down-counter (load, value, expired). Shared by the
//   response timeout and the cooldown, because only one of them is active at a time.
// TESTING
//  Correct PIN, NUM_DIGITS one-hot submits -> 4 pin_submit pulses, each 1 cycle after its
//   user_submit; correct -> access=1; user_done -> chk_reset, READY.
//  3 wrong PINs (MAX_FAILS=3) -> fails_left 3->2->1->0; locked=1 for exactly 1000 cycles;
//   then fails_left=3.
//  Submit during COOLDOWN or GRANTED -> no pin_submit; user_digits=4'b0110 in READY ->
//   bad_digit pulse, digit_cnt unchanged.
//  No verdict for 8 cycles in CHECK -> counted as a failure, fails_left decrements.
//  pin_bug in CHECK -> fault=1 sticky (macro off); chk_reset pulse, fails_left-- (macro on).
//  Reset asserted in COOLDOWN and in the middle of digit entry -> all outputs at reset values
//   asynchronously.

Source files
------------

// File: rtl/pin_ctrl_pkg.sv
// Shared state encoding and helpers for the PIN attempt controller.
package pin_ctrl_pkg;

  typedef enum logic [2:0] {
    READY    = 3'd0,
    CHECK    = 3'd1,
    GRANTED  = 3'd2,
    COOLDOWN = 3'd3,
    FAULT    = 3'd4
  } state_t;

  // FAIL_W helper: bits needed to hold 0..max_fails.
  function automatic int fail_w(input int max_fails);
    return $clog2(max_fails + 1);
  endfunction

  function automatic logic is_onehot4(input logic [3:0] d);
    return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/pin_ctrl_timer.sv
// Loadable down-counter shared by the response timeout and the cooldown lockout.
module pin_ctrl_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // High during the last loaded cycle, so a load of N spans exactly N cycles.
  assign expired = (cnt == W'(1));

endmodule

// File: rtl/pin_attempt_ctrl.sv
// Session controller in front of the DebitPin checker: forwards digits, tracks failures, locks out.
// Build option: define PIN_BUG_RECOVER_EN to treat pin_bug as a failed attempt instead of sticky FAULT.
module pin_attempt_ctrl
  import pin_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int MAX_FAILS       = 3,
  parameter int COOLDOWN_CYCLES = 1000,
  parameter int RESP_TIMEOUT    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    user_digits,
  input  logic                          user_submit,
  input  logic                          user_done,
  input  logic                          pin_correct,
  input  logic                          pin_incorrect,
  input  logic                          pin_bug,
  output logic [3:0]                    pin_digits,
  output logic                          pin_submit,
  output logic                          chk_reset,
  output logic                          access,
  output logic                          locked,
  output logic                          fault,
  output logic                          bad_digit,
  output logic [fail_w(MAX_FAILS)-1:0]  fails_left
);

  localparam int FAIL_W = fail_w(MAX_FAILS);
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int TMR_W  = $clog2(((COOLDOWN_CYCLES > RESP_TIMEOUT) ? COOLDOWN_CYCLES
                                                                  : RESP_TIMEOUT) + 1);

  localparam logic [2:0] ST_READY    = READY;
  localparam logic [2:0] ST_CHECK    = CHECK;
  localparam logic [2:0] ST_GRANTED  = GRANTED;
  localparam logic [2:0] ST_COOLDOWN = COOLDOWN;
  localparam logic [2:0] ST_FAULT    = FAULT;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  digit_cnt, cnt_nxt;
  logic [FAIL_W-1:0] fails_nxt;
  logic [3:0]        dig_nxt;
  logic              sub_nxt, bad_nxt, crst_nxt, fail_evt;
  logic              tmr_load, tmr_expired;
  logic [TMR_W-1:0]  tmr_value;

  pin_ctrl_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = digit_cnt;
    fails_nxt = fails_left;
    dig_nxt   = pin_digits;
    sub_nxt   = 1'b0;
    bad_nxt   = 1'b0;
    crst_nxt  = 1'b0;
    fail_evt  = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = TMR_W'(RESP_TIMEOUT);

    // A simultaneous correct+incorrect verdict is a checker malfunction, same as pin_bug.
    if (state != ST_FAULT &&
        (pin_bug || (state == ST_CHECK && pin_correct && pin_incorrect))) begin
`ifdef PIN_BUG_RECOVER_EN
      fail_evt = 1'b1;
      crst_nxt = 1'b1;
`else
      state_nxt = ST_FAULT;
`endif
    end else begin
      case (state)
        ST_READY: begin
          if (user_submit) begin
            if (is_onehot4(user_digits)) begin
              dig_nxt = user_digits;
              sub_nxt = 1'b1;
              cnt_nxt = digit_cnt + CNT_W'(1);
              if (cnt_nxt == CNT_W'(NUM_DIGITS)) begin
                state_nxt = ST_CHECK;
                tmr_load  = 1'b1;
                tmr_value = TMR_W'(RESP_TIMEOUT);
              end
            end else begin
              bad_nxt = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (pin_correct) begin
            state_nxt = ST_GRANTED;
            fails_nxt = FAIL_W'(MAX_FAILS);
          end else if (pin_incorrect || tmr_expired) begin
            fail_evt = 1'b1;
          end
        end
        ST_GRANTED: begin
          if (user_done) begin
            state_nxt = ST_READY;
            crst_nxt  = 1'b1;
          end
        end
        ST_COOLDOWN: begin
          if (tmr_expired) begin
            state_nxt = ST_READY;
            crst_nxt  = 1'b1;
            fails_nxt = FAIL_W'(MAX_FAILS);
          end
        end
        default: ;
      endcase
    end

    if (fail_evt) begin
      fails_nxt = (fails_left == '0) ? '0 : fails_left - FAIL_W'(1);
      if (fails_nxt == '0) begin
        state_nxt = ST_COOLDOWN;
        tmr_load  = 1'b1;
        tmr_value = TMR_W'(COOLDOWN_CYCLES);
      end else begin
        state_nxt = ST_READY;
        crst_nxt  = 1'b1;
      end
    end

    if (crst_nxt) cnt_nxt = '0;
  end

  // chk_reset comes out of reset high so the checker is cleared alongside this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_READY;
      digit_cnt  <= '0;
      fails_left <= FAIL_W'(MAX_FAILS);
      pin_digits <= '0;
      pin_submit <= 1'b0;
      bad_digit  <= 1'b0;
      chk_reset  <= 1'b1;
    end else begin
      state      <= state_nxt;
      digit_cnt  <= cnt_nxt;
      fails_left <= fails_nxt;
      pin_digits <= dig_nxt;
      pin_submit <= sub_nxt;
      bad_digit  <= bad_nxt;
      chk_reset  <= crst_nxt;
    end
  end

  assign access = (state == ST_GRANTED);
  assign locked = (state == ST_COOLDOWN);
  assign fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_pin_attempt_ctrl.sv
// Directed bench for pin_attempt_ctrl with a scoreboard of forwarded digits.
module tb_pin_attempt_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] user_digits = '0;
  logic       user_submit = 1'b0;
  logic       user_done = 1'b0;
  logic       pin_correct = 1'b0;
  logic       pin_incorrect = 1'b0;
  logic       pin_bug = 1'b0;
  logic [3:0] pin_digits;
  logic       pin_submit, chk_reset, access, locked, fault, bad_digit;
  logic [1:0] fails_left;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];

  pin_attempt_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .user_digits   (user_digits),
    .user_submit   (user_submit),
    .user_done     (user_done),
    .pin_correct   (pin_correct),
    .pin_incorrect (pin_incorrect),
    .pin_bug       (pin_bug),
    .pin_digits    (pin_digits),
    .pin_submit    (pin_submit),
    .chk_reset     (chk_reset),
    .access        (access),
    .locked        (locked),
    .fault         (fault),
    .bad_digit     (bad_digit),
    .fails_left    (fails_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every forwarded digit must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && pin_submit) begin
      if (sb.size() == 0) check("unexpected_submit", 32'(pin_submit), 32'd0);
      else check("pin_digits", 32'(pin_digits), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] d, input bit fwd, input bit bad);
    user_digits = d;
    user_submit = 1'b1;
    if (fwd) sb.push_back(d);
    @(negedge clk);
    user_submit = 1'b0;
    user_digits = '0;
    check("pin_submit_latency", 32'(pin_submit), 32'(fwd));
    check("bad_digit", 32'(bad_digit), 32'(bad));
  endtask

  task automatic enter_pin();
    for (int i = 0; i < 4; i++) send(4'b0001 << i, 1'b1, 1'b0);
  endtask

  task automatic wrong_pin(input logic [1:0] exp_fails);
    enter_pin();
    pin_incorrect = 1'b1;
    tick();
    pin_incorrect = 1'b0;
    check("fails_left_wrong", 32'(fails_left), 32'(exp_fails));
    check("chk_reset_wrong", 32'(chk_reset), (exp_fails != 0) ? 32'd1 : 32'd0);
    check("locked_wrong", 32'(locked), (exp_fails == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic check_reset_vals(input string where);
    check({where, "_access"}, 32'(access), 32'd0);
    check({where, "_locked"}, 32'(locked), 32'd0);
    check({where, "_fault"}, 32'(fault), 32'd0);
    check({where, "_bad"}, 32'(bad_digit), 32'd0);
    check({where, "_submit"}, 32'(pin_submit), 32'd0);
    check({where, "_digits"}, 32'(pin_digits), 32'd0);
    check({where, "_chk_reset"}, 32'(chk_reset), 32'd1);
    check({where, "_fails"}, 32'(fails_left), 32'd3);
  endtask

  task automatic async_reset(input string where);
    #2 reset = 1'b1;
    #1 check_reset_vals(where);
    @(negedge clk);
    reset = 1'b0;
    #1 check({where, "_chk_reset_hold"}, 32'(chk_reset), 32'd1);
    @(negedge clk);
    check({where, "_chk_reset_drop"}, 32'(chk_reset), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) tick();
    check_reset_vals("por");
    reset = 1'b0;
    #1 check("por_chk_reset_hold", 32'(chk_reset), 32'd1);
    tick();
    check("por_chk_reset_drop", 32'(chk_reset), 32'd0);

    // Correct PIN, then access, submit ignored while granted, then end of session.
    enter_pin();
    check("access_before_verdict", 32'(access), 32'd0);
    pin_correct = 1'b1;
    tick();
    pin_correct = 1'b0;
    check("access_granted", 32'(access), 32'd1);
    check("fails_after_ok", 32'(fails_left), 32'd3);
    send(4'b0001, 1'b0, 1'b0);
    check("access_hold", 32'(access), 32'd1);
    user_done = 1'b1;
    tick();
    user_done = 1'b0;
    check("done_chk_reset", 32'(chk_reset), 32'd1);
    check("done_access", 32'(access), 32'd0);
    tick();
    check("done_chk_reset_drop", 32'(chk_reset), 32'd0);
    check("sb_empty_ok", 32'(sb.size()), 32'd0);

    // Non-one-hot submits are rejected and not counted.
    send(4'b0110, 1'b0, 1'b1);
    send(4'b0000, 1'b0, 1'b1);

    // Three wrong PINs lead to lockout.
    wrong_pin(2'd2);
    wrong_pin(2'd1);
    wrong_pin(2'd0);
    n = 0;
    send(4'b0100, 1'b0, 1'b0);
    n = 1;
    while (locked && n < 1100) begin
      n++;
      tick();
    end
    check("cooldown_len", 32'(n), 32'd1000);
    check("cooldown_exit_locked", 32'(locked), 32'd0);
    check("cooldown_exit_chk_reset", 32'(chk_reset), 32'd1);
    check("cooldown_exit_fails", 32'(fails_left), 32'd3);
    tick();
    check("sb_empty_cool", 32'(sb.size()), 32'd0);

    // No verdict: forced failure after exactly 8 cycles in CHECK.
    enter_pin();
    repeat (7) tick();
    check("timeout_not_yet", 32'(fails_left), 32'd3);
    tick();
    check("timeout_fails", 32'(fails_left), 32'd2);
    check("timeout_chk_reset", 32'(chk_reset), 32'd1);
    tick();

    // Checker internal error while waiting for a verdict.
    enter_pin();
    pin_bug = 1'b1;
    tick();
    pin_bug = 1'b0;
`ifdef PIN_BUG_RECOVER_EN
    check("bug_fault", 32'(fault), 32'd0);
    check("bug_chk_reset", 32'(chk_reset), 32'd1);
    check("bug_fails", 32'(fails_left), 32'd1);
    tick();
`else
    check("bug_fault", 32'(fault), 32'd1);
    check("bug_access", 32'(access), 32'd0);
    pin_correct = 1'b1;
    tick();
    pin_correct = 1'b0;
    user_done = 1'b1;
    tick();
    user_done = 1'b0;
    send(4'b0001, 1'b0, 1'b0);
    check("bug_fault_sticky", 32'(fault), 32'd1);
    check("bug_access_sticky", 32'(access), 32'd0);
`endif
    async_reset("rst_after_bug");

    // Reset in the middle of digit entry.
    send(4'b0010, 1'b1, 1'b0);
    send(4'b1000, 1'b1, 1'b0);
    async_reset("rst_mid_entry");

    // Reset during cooldown.
    wrong_pin(2'd2);
    wrong_pin(2'd1);
    wrong_pin(2'd0);
    repeat (5) tick();
    check("locked_before_rst", 32'(locked), 32'd1);
    async_reset("rst_cooldown");

    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
